// File: rtl/mdu_unit.sv
// mdu_unit: iterative RV32M multiply/divide unit, one bit per cycle.
// Ports: clk/rst, kill_i abort, in_* request handshake, out_* result.
module mdu_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kill_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] rs1_val_i,
  input  logic [DATA_WIDTH-1:0] rs2_val_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ADDR_WIDTH-1:0] rd_o,
  output logic [DATA_WIDTH-1:0] dat_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [W-1:0] MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [2:0]    f3_q;
  logic          neg_a_q;
  logic          neg_b_q;
  logic          spec_q;
  logic [W:0]    hi_q;
  logic [W-1:0]  lo_q;
  logic [W-1:0]  opnd_q;
  logic [CW-1:0] cnt_q;

  logic accept;
  logic last;
  logic step_en;
  logic fix_en;
  logic spec_en;

  assign accept = in_valid_i & in_ready_o & ~kill_i;
  assign last   = (cnt_q == CW'(W - 1));

  // Request decode: signedness, magnitudes, special cases.
  logic         a_sgn;
  logic         b_sgn;
  logic         neg_a;
  logic         neg_b;
  logic         div_req;
  logic         b_zero;
  logic         ovf;
  logic         spec;
  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;
  logic [W-1:0] spec_res;

  always_comb begin
    a_sgn = 1'b1;
    b_sgn = 1'b1;
    unique case (1'b1)
      funct3_i == 3'd2: b_sgn = 1'b0;
      funct3_i == 3'd3,
      funct3_i == 3'd5,
      funct3_i == 3'd7: begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
      end
      default: ;
    endcase
    neg_a   = a_sgn & rs1_val_i[W-1];
    neg_b   = b_sgn & rs2_val_i[W-1];
    mag_a   = neg_a ? (~rs1_val_i + 1'b1) : rs1_val_i;
    mag_b   = neg_b ? (~rs2_val_i + 1'b1) : rs2_val_i;
    div_req = funct3_i[2];
    b_zero  = (rs2_val_i == '0);
    // Only the signed DIV/REM encodings (4, 6) can overflow.
    ovf     = ~funct3_i[0] & (rs1_val_i == MIN)
            & (rs2_val_i == ONES);
    spec    = div_req & (b_zero | ovf);
    if (b_zero)
      spec_res = funct3_i[1] ? rs1_val_i : ONES;
    else
      spec_res = funct3_i[1] ? '0 : MIN;
  end

  // One iteration step for each algorithm.
  logic [W:0] add_s;
  logic [W:0] sh_s;
  logic [W:0] sub_s;

  always_comb begin
    add_s = hi_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
    sh_s  = {hi_q[W-1:0], lo_q[W-1]};
    // Top bit set means the trial subtraction borrowed.
    sub_s = sh_s - {1'b0, opnd_q};
  end

  // Sign correction and result select.
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   res;

  always_comb begin
    prod     = {hi_q[W-1:0], lo_q};
    prod_fix = (neg_a_q ^ neg_b_q) ? (~prod + 1'b1) : prod;
    quo      = (neg_a_q ^ neg_b_q) ? (~lo_q + 1'b1) : lo_q;
    rem      = neg_a_q ? (~hi_q[W-1:0] + 1'b1) : hi_q[W-1:0];
    unique case (f3_q)
      3'd0:    res = prod_fix[W-1:0];
      3'd1,
      3'd2,
      3'd3:    res = prod_fix[2*W-1:W];
      3'd4,
      3'd5:    res = quo;
      default: res = rem;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept) state_d = CALC;
        CALC: begin
          if (spec_q)
            state_d = DONE;
          else if (last)
            state_d = FIX;
        end
        FIX:  state_d = DONE;
        DONE: if (out_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs and datapath strobes.
  always_comb begin
    in_ready_o  = (state_q == IDLE) & ~rst;
    out_valid_o = (state_q == DONE);
    step_en     = (state_q == CALC) & ~spec_q;
    spec_en     = (state_q == CALC) & spec_q;
    fix_en      = (state_q == FIX);
  end

  // Datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      spec_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      rd_o    <= '0;
      dat_o   <= '0;
    end else if (kill_i) begin
      cnt_q  <= '0;
      spec_q <= 1'b0;
    end else begin
      if (accept) begin
        f3_q    <= funct3_i;
        rd_o    <= rd_i;
        neg_a_q <= neg_a;
        neg_b_q <= neg_b;
        spec_q  <= spec;
        cnt_q   <= '0;
        hi_q    <= '0;
        // Special results ride in lo_q for one cycle.
        if (spec) begin
          lo_q   <= spec_res;
          opnd_q <= '0;
        end else if (div_req) begin
          lo_q   <= mag_a;
          opnd_q <= mag_b;
        end else begin
          lo_q   <= mag_b;
          opnd_q <= mag_a;
        end
      end
      if (step_en) begin
        cnt_q <= cnt_q + 1'b1;
        if (!f3_q[2]) begin
          hi_q <= {1'b0, add_s[W:1]};
          lo_q <= {add_s[0], lo_q[W-1:1]};
        end else if (sub_s[W]) begin
          hi_q <= sh_s;
          lo_q <= {lo_q[W-2:0], 1'b0};
        end else begin
          hi_q <= sub_s;
          lo_q <= {lo_q[W-2:0], 1'b1};
        end
      end
      if (spec_en)
        dat_o <= lo_q;
      if (fix_en)
        dat_o <= res;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors, corner sequences and random ops.
// Checks results, latency, rd pass-through and handshakes.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        kill_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_val_i;
  logic [31:0] rs2_val_i;
  logic [4:0]  rd_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [4:0]  rd_o;
  logic [31:0] dat_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mdu_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .kill_i     (kill_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .funct3_i   (funct3_i),
    .rs1_val_i  (rs1_val_i),
    .rs2_val_i  (rs2_val_i),
    .rd_i       (rd_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .rd_o       (rd_o),
    .dat_o      (dat_o)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, za, zb, p;
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ea  = {{32{a[31]}}, a};
    eb  = {{32{b[31]}}, b};
    za  = {32'b0, a};
    zb  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = za * zb; return p[31:0]; end
      3'd1: begin p = ea * eb; return p[63:32]; end
      3'd2: begin p = ea * zb; return p[63:32]; end
      3'd3: begin p = za * zb; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000
        && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called at posedge+1; returns at acceptance edge+1.
  task automatic start(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    int n;
    n = 0;
    while (!in_ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("start_ready", {31'b0, in_ready_o}, 32'd1);
    funct3_i   = f3;
    rs1_val_i  = a;
    rs2_val_i  = b;
    rd_i       = rd;
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    funct3_i   = 3'($urandom);
    rs1_val_i  = $urandom;
    rs2_val_i  = $urandom;
    rd_i       = 5'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (out_valid_o) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic ack();
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic run(input string name, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp,
                     input int exp_lat);
    int lat;
    start(f3, a, b, rd);
    wait_valid(lat);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_dat"}, dat_o, exp);
    check({name, "_rd"}, {27'b0, rd_o}, {27'b0, rd});
    ack();
    check({name, "_rdy"}, {31'b0, in_ready_o}, 32'd1);
  endtask

  initial begin
    logic [31:0] a, b, d0;
    logic [2:0]  f3;
    int lat;
    logic seen;

    vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 33};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         5'd4,  32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         33};
    vecs[8]  = '{3'd4, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd7, 32'd5,         32'd0,         5'd10, 32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'd0,         1};
    vecs[12] = '{3'd0, 32'h1234_5678, 32'h10,        5'd31, 32'h2345_6780, 33};
    vecs[13] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         33};
    vecs[14] = '{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 33};
    vecs[15] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'd0,         33};

    rst         = 1'b1;
    kill_i      = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    funct3_i    = '0;
    rs1_val_i   = '0;
    rs2_val_i   = '0;
    rd_i        = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, out_valid_o}, 32'd0);
    check("rst_ready", {31'b0, in_ready_o}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_rd", {27'b0, rd_o}, 32'd0);
    rst = 1'b0;
    #1;
    check("rel_ready", {31'b0, in_ready_o}, 32'd1);

    // Directed table
    for (int i = 0; i < 16; i++)
      run($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
          vecs[i].rd, vecs[i].exp, vecs[i].lat);

    // Backpressure in DONE
    start(3'd0, 32'd6, 32'd7, 5'd5);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'd33);
    d0 = dat_o;
    check("bp_dat", d0, 32'd42);
    funct3_i   = 3'd0;
    rs1_val_i  = 32'd9;
    rs2_val_i  = 32'd9;
    rd_i       = 5'd20;
    in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_dat", dat_o, 32'd42);
      check("bp_hold_rd", {27'b0, rd_o}, 32'd5);
      check("bp_hold_rdy", {31'b0, in_ready_o}, 32'd0);
      check("bp_hold_vld", {31'b0, out_valid_o}, 32'd1);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    check("bp_rel_rdy", {31'b0, in_ready_o}, 32'd1);
    check("bp_rel_vld", {31'b0, out_valid_o}, 32'd0);

    // Request together with kill is dropped
    funct3_i   = 3'd0;
    rs1_val_i  = 32'd2;
    rs2_val_i  = 32'd2;
    in_valid_i = 1'b1;
    kill_i     = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    kill_i     = 1'b0;
    check("kill_req_rdy", {31'b0, in_ready_o}, 32'd1);

    // Abort a divide mid-CALC
    start(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3);
    repeat (9) @(posedge clk);
    #1;
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    check("kill_rdy", {31'b0, in_ready_o}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen |= out_valid_o;
    end
    check("kill_no_vld", {31'b0, seen}, 32'd0);
    run("kill_next", 3'd0, 32'd3, 32'd4, 5'd17, 32'd12, 33);

    // Reset mid-CALC
    start(3'd0, 32'd5, 32'd5, 5'd7);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_vld", {31'b0, out_valid_o}, 32'd0);
    check("mrst_rdy", {31'b0, in_ready_o}, 32'd0);
    check("mrst_dat", dat_o, 32'd0);
    check("mrst_rd", {27'b0, rd_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mrst_rel_rdy", {31'b0, in_ready_o}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen |= out_valid_o;
    end
    check("mrst_no_vld", {31'b0, seen}, 32'd0);

    // Random operands against the reference model
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 3; k++) begin
        f3 = 3'(f);
        a  = $urandom;
        b  = (k == 1) ? 32'($urandom_range(0, 7)) : $urandom;
        run($sformatf("rnd_f%0d_%0d", f, k), f3, a, b, 5'($urandom),
            ref_mdu(f3, a, b), ref_lat(f3, a, b));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Iterative RV32M multiply/divide unit for the NPC execute stage. It consumes the two source values read from the register file along with the destination register index. It returns one result word plus that index through a valid/ready handshake, and the write-back logic forwards the pair into the register file write port. One operation is in flight at a time; multiply and divide each retire one bit per cycle.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.
- `ADDR_WIDTH`, default 5: register index width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `kill_i`  in  1  synchronous abort of the operation in flight.
- `in_valid_i`  in  1  request valid.
- `in_ready_o`  out  1  unit idle and able to accept a request.
- `funct3_i`  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_val_i`  in  DATA_WIDTH  operand A (multiplicand / dividend).
- `rs2_val_i`  in  DATA_WIDTH  operand B (multiplier / divisor).
- `rd_i`  in  ADDR_WIDTH  destination index, carried through unchanged.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts the result.
- `rd_o`  out  ADDR_WIDTH  destination index of the result.
- `dat_o`  out  DATA_WIDTH  result word.

## Operation
- States:
  - IDLE: `in_ready_o`=1.
  - CALC: iterating.
  - FIX: sign correction and result select.
  - DONE: `out_valid_o`=1.
- IDLE, on `in_valid_i & in_ready_o`:
  - Latch `funct3_i`, `rd_i`, and the operand magnitudes.
  - Signedness comes from funct3:
    - MULHSU: A is signed, B is unsigned.
    - DIVU, REMU, MULHU: both operands unsigned.
    - All other ops: both operands signed.
  - Latch the result sign flags.
  - Clear the iteration counter and go to CALC.
- Special cases skip CALC and FIX and go straight to DONE:
  - Divide by zero: quotient = all ones; remainder = dividend (raw A).
  - Signed overflow (DIV/REM with A = 0x8000_0000 and B = all ones): quotient = 0x8000_0000; remainder = 0.
- Multiply in CALC: shift-add on magnitudes into a 2*DATA_WIDTH product register, one multiplier bit per cycle.
- Divide in CALC: restoring division on magnitudes, one quotient bit per cycle; the remainder register is DATA_WIDTH+1 bits.
- CALC lasts exactly DATA_WIDTH cycles, then goes to FIX.
- FIX:
  - Negate the product if the operand signs differ.
  - Quotient sign = sign A xor sign B.
  - Remainder sign = sign of A.
  - Select the result word:
    - MUL: low half of the product.
    - MULH, MULHSU, MULHU: high half.
    - DIV, DIVU: quotient.
    - REM, REMU: remainder.
  - Register `dat_o`, then go to DONE.
- DONE:
  - `dat_o` and `rd_o` hold stable while `out_valid_o`=1.
  - On `out_ready_i`, go to IDLE.
- `rd_i`=0 is computed normally; the register file drops the write.
- `kill_i`:
  - In any state, the next state is IDLE and `out_valid_o` deasserts on the next edge.
  - A request presented in the same cycle as `kill_i` is not accepted.
- `rst` takes priority over `kill_i`, and `kill_i` takes priority over the handshakes.

## Timing
- Reset values: state IDLE, `out_valid_o`=0, `dat_o`=0, `rd_o`=0, counter=0.
- `in_ready_o` = (state==IDLE) and not `rst`.
- Request accepted on edge E0:
  - Normal op: `out_valid_o` rises after edge E0+DATA_WIDTH+1 (33 cycles at default width).
  - Special case: `out_valid_o` rises after E0+1.
- Result accepted on edge Ed (`out_valid_o & out_ready_i`): `in_ready_o`=1 from Ed+1. There is no same-cycle result-to-request turnaround.
- Back-to-back throughput: one operation per DATA_WIDTH+3 cycles.
- `rst` or `kill_i` asserted mid-CALC: the state is IDLE after that edge; partial results are discarded and never presented.
- Inputs are sampled only on the acceptance edge. Later changes to the operand inputs do not affect the operation in flight.

## Test plan
- Multiply results:
  - MUL 7 × 0xFFFF_FFFD (−3): `dat_o`=0xFFFF_FFEB.
  - MULH 0x8000_0000 × 0x8000_0000: 0x4000_0000.
  - MULHU 0xFFFF_FFFF × 0xFFFF_FFFF: 0xFFFF_FFFE.
  - MULHSU 0xFFFF_FFFF × 2: 0xFFFF_FFFF.
  - Each with `out_valid_o` exactly 33 cycles after acceptance.
- Divide results:
  - DIV −7/2: 0xFFFF_FFFD.
  - REM −7/2: 0xFFFF_FFFF.
  - DIVU 100/7: 14.
  - REMU 100/7: 2.
- Special cases, each with `out_valid_o` one cycle after acceptance:
  - DIV 5/0: 0xFFFF_FFFF.
  - REMU 5/0: 5.
  - DIV 0x8000_0000 / 0xFFFF_FFFF: 0x8000_0000.
  - REM of the same operands: 0.
- Backpressure: hold `out_ready_i`=0 for 5 cycles in DONE -> `dat_o`/`rd_o` stable, `in_ready_o`=0, and a pending `in_valid_i` is not accepted. Then raise `out_ready_i` -> `in_ready_o`=1 on the next cycle.
- Abort: assert `kill_i` 10 cycles into a DIV -> IDLE next cycle, no `out_valid_o` ever for that op. A following MUL 3×4 returns 12 with rd carried through.
- Reset: `rst` mid-CALC -> all outputs 0 and `in_ready_o`=0 during reset, `in_ready_o`=1 the cycle after release. Random operands vs. a reference model for all 8 funct3 values.
